// File: rtl/lift_request_scheduler.sv
// Lift request scheduler: latches floor requests, picks the next stop with
// SCAN-style ordering, and sequences MOVE / DOOR dwell for a 4-floor car.
module lift_request_scheduler #(
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_btn,
   input  logic [1:0] current_floor,
   input  logic       motor_up,
   input  logic       motor_down,
   output logic [1:0] floor_button,
   output logic [3:0] pending,
   output logic       door_open,
   output logic       dir_down,
   output logic       busy
);

   localparam int unsigned NFLOORS = 4;
   localparam int unsigned FW      = 2;
   localparam int unsigned DW      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [NFLOORS-1:0] pending_q, pending_d;
   logic [FW-1:0]   floor_button_q, floor_button_d;
   logic            door_open_q, door_open_d;
   logic            dir_down_q, dir_down_d;
   logic [DW-1:0]   dwell_q, dwell_d;

   logic            above_found, below_found;
   logic [FW-1:0]   above_flr, below_flr, target;
   logic            enter_door;

   // Nearest pending floor above and below the car, then pick by direction.
   always_comb begin
      above_found = 1'b0;
      above_flr   = '0;
      below_found = 1'b0;
      below_flr   = '0;
      for (int i = int'(NFLOORS) - 1; i >= 0; i--) begin
         if (pending_q[i] && (FW'(i) > current_floor)) begin
            above_found = 1'b1;
            above_flr   = FW'(i);
         end
      end
      for (int i = 0; i < int'(NFLOORS); i++) begin
         if (pending_q[i] && (FW'(i) < current_floor)) begin
            below_found = 1'b1;
            below_flr   = FW'(i);
         end
      end
      if (!dir_down_q) begin
         target = above_found ? above_flr : below_flr;
      end else begin
         target = below_found ? below_flr : above_flr;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q | req_btn;
      floor_button_d = floor_button_q;
      door_open_d    = door_open_q;
      dir_down_d     = dir_down_q;
      dwell_d        = dwell_q;
      enter_door     = 1'b0;

      case (state_q)
         IDLE: begin
            if (pending_q[current_floor]) begin
               enter_door = 1'b1;
            end else if (|pending_q) begin
               state_d        = MOVE;
               floor_button_d = target;
               dir_down_d     = !(target > current_floor);
            end
         end
         MOVE: begin
            if ((current_floor == floor_button_q) && !motor_up && !motor_down) begin
               enter_door = 1'b1;
            end
         end
         DOOR: begin
            // A press at the open floor is absorbed by the stop in progress.
            pending_d[current_floor] = 1'b0;
            if (dwell_q == '0) begin
               door_open_d = 1'b0;
               state_d     = IDLE;
            end else begin
               dwell_d = dwell_q - DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (enter_door) begin
         state_d                  = DOOR;
         pending_d[current_floor] = 1'b0;
         dwell_d                  = DW'(DOOR_CYCLES - 1);
         door_open_d              = 1'b1;
      end
   end

   // State and output registers; reset discards every outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         pending_q      <= '0;
         floor_button_q <= '0;
         door_open_q    <= 1'b0;
         dir_down_q     <= 1'b0;
         dwell_q        <= '0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         floor_button_q <= floor_button_d;
         door_open_q    <= door_open_d;
         dir_down_q     <= dir_down_d;
         dwell_q        <= dwell_d;
      end
   end

   assign floor_button = floor_button_q;
   assign pending      = pending_q;
   assign door_open    = door_open_q;
   assign dir_down     = dir_down_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: doc/lift_request_scheduler.md
LIFT_REQUEST_SCHEDULER -- requirements
Module: lift_request_scheduler

Interface
REQ-001 SHALL provide parameter: DOOR_CYCLES, default 4, number of clock cycles door_open is held high per stop (legal range 1..255).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: req_btn  input  4  floor request buttons, bit i = floor i, may be pulses or held levels, any number set per cycle.
REQ-005 SHALL provide port: current_floor  input  2  car position from lift controller.
REQ-006 SHALL provide port: motor_up  input  1  lift controller up-motor status.
REQ-007 SHALL provide port: motor_down  input  1  lift controller down-motor status.
REQ-008 SHALL provide port: floor_button  output  2  registered target floor fed to the lift controller.
REQ-009 SHALL provide port: pending  output  4  registered outstanding-request vector.
REQ-010 SHALL provide port: door_open  output  1  registered door command.
REQ-011 SHALL provide port: dir_down  output  1  registered travel direction, 0 = up, 1 = down.
REQ-012 SHALL provide port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, MOVE, DOOR.
REQ-014 SHALL set pending[i] on every rising edge where req_btn[i]=1, except as REQ-022 states.
REQ-015 SHALL, in IDLE with pending==0, hold state, floor_button, and dir_down unchanged.
REQ-016 SHALL, in IDLE with pending[current_floor]=1, go to DOOR next edge without changing floor_button.
REQ-017 SHALL, in IDLE with pending!=0 and pending[current_floor]=0, select the target per REQ-018, load floor_button with it, and enter MOVE, all on the same edge.
REQ-018 SHALL select targets SCAN-style:
 - dir_down=0: lowest pending floor above current_floor; if none, highest pending floor below it.
 - dir_down=1: highest pending floor below current_floor; if none, lowest pending floor above it.
REQ-019 SHALL set dir_down on the MOVE-entry edge: 0 if target>current_floor, 1 otherwise.
REQ-020 SHALL, in MOVE, hold floor_button constant; new requests do not retarget the car.
 - Leave MOVE for DOOR when current_floor==floor_button && motor_up==0 && motor_down==0.
REQ-021 SHALL, on the DOOR-entry edge, clear pending[current_floor], load the dwell counter with DOOR_CYCLES-1, and assert door_open.
REQ-022 SHALL, in DOOR, hold pending[current_floor]=0 regardless of req_btn (press absorbed); other floors still latch.
REQ-023 SHALL keep door_open=1 for exactly DOOR_CYCLES cycles, then deassert it and return to IDLE on the same edge.
REQ-024 SHALL derive busy combinationally from state; all other outputs are registered.
REQ-025 SHALL give end-to-end latency: press sampled at edge E0 -> floor_button valid and busy=1 after edge E1 (when idle with floor_button!=target).
REQ-026 SHALL use 2-bit unsigned floor compares; floors 0 and 3 are the ends, with no wrap-around.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, pending=0, floor_button=0, door_open=0, dir_down=0, dwell counter=0, and busy=0 immediately.
REQ-028 SHALL, on reset asserted mid-MOVE or mid-DOOR, discard all requests; no request survives reset.

Verification
REQ-029 SHALL cover: reset, then pulse req_btn=4'b0100 at floor 0 -> floor_button=2 and busy=1 one edge after latch; car arrives -> door_open high 4 cycles; pending=0; back to IDLE.
REQ-030 SHALL cover: car at 1, dir up, pending {0,3} set together -> serves 3 first, then 0, with dir_down toggling 0->1.
REQ-031 SHALL cover: idle at floor 2, press floor 2 -> DOOR directly, floor_button stays 2, no motor activity.
REQ-032 SHALL cover: press current floor during DOOR -> pending bit stays 0 and dwell is not extended; press floor 1 during DOOR -> pending[1]=1, served next.
REQ-033 SHALL cover: rst_n low mid-MOVE with pending=4'b1010 -> all outputs at reset values asynchronously, with no dispatch after release.
REQ-034 SHALL cover: DOOR_CYCLES=1 -> door_open is a single-cycle pulse.
